// File: rtl/adder_subtractor.sv
// adder_subtractor: two's-complement ripple-carry add/subtract with registered result, carry and overflow.
// Subtraction inverts b bit-by-bit and injects select as the chain's carry-in.
module adder_subtractor_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module adder_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] s;

    assign b_eff = b ^ {WIDTH{select}};
    assign c[0]  = select;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        adder_subtractor_fa u_fa (
            .a  (a[i]),
            .b  (b_eff[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            r    <= s;
            cout <= c[WIDTH];
            // Signed overflow: carries into and out of the sign bit disagree
            ovf  <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_adder_subtractor.sv
// tb_adder_subtractor: directed, exhaustive and random checks against an arithmetic reference model.
module tb_adder_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         select = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] r;
    logic         cout;
    logic         ovf;

    int n_vec = 0;
    int n_err = 0;

    adder_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .select (select),
        .a      (a),
        .b      (b),
        .r      (r),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference from signed/unsigned arithmetic rather than the carry chain
    function automatic void model(input bit sel, input int ua, input int ub,
                                  output int er, output int ec, output int eo);
        int m, sa, sb, res, raw;
        m   = 1 << W;
        sa  = (ua >= m / 2) ? ua - m : ua;
        sb  = (ub >= m / 2) ? ub - m : ub;
        res = sel ? sa - sb : sa + sb;
        raw = sel ? ua - ub : ua + ub;
        er  = ((raw % m) + m) % m;
        ec  = sel ? int'(ua >= ub) : int'(ua + ub >= m);
        eo  = int'(res < -(m / 2) || res > m / 2 - 1);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".r"}, int'(r), 0);
        check({tag, ".cout"}, int'(cout), 0);
        check({tag, ".ovf"}, int'(ovf), 0);
    endtask

    task automatic apply(input string tag, input bit sel, input int ua, input int ub);
        int er, ec, eo;
        @(negedge clk);
        select = sel;
        a = W'(ua);
        b = W'(ub);
        model(sel, ua, ub, er, ec, eo);
        @(posedge clk);
        #1;
        check({tag, ".r"}, int'(r), er);
        check({tag, ".cout"}, int'(cout), ec);
        check({tag, ".ovf"}, int'(ovf), eo);
    endtask

    initial begin
        select = 1'b1;
        a = 4'b1011;
        b = 4'b0110;
        #2;
        check_zero("reset_async");
        @(negedge clk);
        check_zero("reset_hold");
        rst_n = 1'b1;

        apply("add_ovf",   1'b0, 4'b0111, 4'b0001);
        apply("add_wrap",  1'b0, 4'b1111, 4'b0001);
        apply("add_plain", 1'b0, 4'b0011, 4'b0100);
        apply("sub_pos",   1'b1, 4'b0101, 4'b0011);
        apply("sub_neg",   1'b1, 4'b0011, 4'b0101);
        apply("sub_ovf1",  1'b1, 4'b1000, 4'b0001);
        apply("sub_ovf2",  1'b1, 4'b0000, 4'b1000);

        for (int k = 0; k < 2 * 16 * 16; k++) begin
            if (k == 300) begin
                @(negedge clk);
                #1 rst_n = 1'b0;
                #1 check_zero("reset_mid");
                #1 rst_n = 1'b1;
            end
            apply("sweep", k[8], k[7:4], k[3:0]);
        end

        // Reset held low across a clock edge must keep outputs at zero
        apply("pre_edge", 1'b0, 4'b0111, 4'b0111);
        @(negedge clk);
        select = 1'b0;
        a = 4'b0101;
        b = 4'b0101;
        rst_n = 1'b0;
        #1 check_zero("reset_now");
        @(posedge clk);
        #1 check_zero("reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        apply("after_rst", 1'b1, 4'b0010, 4'b0111);

        for (int k = 0; k < 200; k++)
            apply("rand", 1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
